// File: rtl/mileage_tube_driver_pkg.sv
// Shared constants for the mileage display path: digit count, clamp limit,
// converter state encodings and the seven-segment glyph table.
package mileage_tube_driver_pkg;

  localparam int unsigned NUM_DIGITS    = 6;
  localparam int unsigned BCD_W         = 4 * NUM_DIGITS;
  localparam int unsigned BIN_W_DEFAULT = 20;
  localparam int unsigned MAX_MILEAGE   = 999999;

  localparam logic [0:0] CONV_IDLE = 1'b0;
  localparam logic [0:0] CONV_RUN  = 1'b1;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/mileage_tube_driver_bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD converter: one iteration per clock,
// BIN_W iterations per conversion; start is ignored while busy.
module bin2bcd_serial
  import mileage_tube_driver_pkg::*;
#(
  parameter int unsigned BIN_W = BIN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [0:0]       state;
  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [CNT_W-1:0] iter;

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // bcd is the accumulator after this cycle's shift, so on the final
  // iteration it is already the finished result the consumer latches.
  assign bcd  = {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
  assign busy = (state == CONV_RUN);
  assign done = busy && (iter == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CONV_IDLE;
      shreg <= '0;
      acc   <= '0;
      iter  <= '0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) begin
            shreg <= bin;
            acc   <= '0;
            iter  <= '0;
            state <= CONV_RUN;
          end
        end
        default: begin
          acc   <= bcd;
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          iter  <= iter + 1'b1;
          if (done) state <= CONV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mileage_tube_driver.sv
// Mileage display driver: clamps and converts the loaded mileage to BCD, then
// scans six digits onto the tube display with leading-zero blanking.
module mileage_tube_driver
  import mileage_tube_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BIN_W    = BIN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [BIN_W-1:0] mileage,
  output logic             busy,
  output logic [7:0]       tube_sel,
  output logic [7:0]       seg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       scan_idx;
  logic [BCD_W-1:0] disp_bcd;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;
  logic [BIN_W-1:0] clamped;
  logic [BCD_W-1:0] upper;
  logic [3:0]       digit;
  logic             blank;
  logic [7:0]       tube_nxt;
  logic [7:0]       seg_nxt;

  assign clamped = (mileage > BIN_W'(MAX_MILEAGE)) ? BIN_W'(MAX_MILEAGE) : mileage;

  bin2bcd_serial #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (load),
    .bin   (clamped),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
      disp_bcd <= '0;
    end else begin
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt  <= '0;
        scan_idx <= (scan_idx == 3'(NUM_DIGITS - 1)) ? '0 : scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (conv_done) disp_bcd <= conv_bcd;
    end
  end

  // A slot is blank when it and every more significant digit are zero;
  // slot 0 is exempt so a zero reading still shows "0".
  always_comb begin
    upper    = disp_bcd >> {scan_idx, 2'b00};
    digit    = upper[3:0];
    blank    = (scan_idx != 3'd0) && (upper == '0);
    tube_nxt = '0;
    seg_nxt  = '0;
    if (enable && !blank) begin
      tube_nxt = 8'b1 << scan_idx;
      seg_nxt  = seg_pattern(digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tube_sel <= '0;
      seg      <= '0;
    end else begin
      tube_sel <= tube_nxt;
      seg      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_mileage_tube_driver.sv
// Directed self-checking bench for mileage_tube_driver with a fast scan
// divider so every slot of a full scan can be observed.
module tb_mileage_tube_driver;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [19:0] mileage;
  logic        busy;
  logic [7:0]  tube_sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_t [24];
  logic [7:0] cap_s [24];

  mileage_tube_driver #(
    .SCAN_DIV (4),
    .BIN_W    (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (load),
    .mileage  (mileage),
    .busy     (busy),
    .tube_sel (tube_sel),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the negedge holding the first sample of slot 0.
  task automatic sync_slot0(output bit ok);
    logic [7:0] prev;
    ok   = 1'b0;
    prev = tube_sel;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tube_sel == 8'h01 && prev != 8'h01) begin
        ok = 1'b1;
        break;
      end
      prev = tube_sel;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL sync_slot0: tube_sel=%h, required a 01 slot start within 100 cycles", tube_sel);
    end
  endtask

  task automatic capture_scan();
    bit ok;
    sync_slot0(ok);
    cap_t[0] = tube_sel;
    cap_s[0] = seg;
    for (int k = 1; k < 24; k++) begin
      @(negedge clk);
      cap_t[k] = tube_sel;
      cap_s[k] = seg;
    end
  endtask

  // Pulses load for v; optionally pulses load for v2 at busy sample pulse_at.
  // Returns at the first negedge with busy low, with load deasserted.
  task automatic do_load(input logic [19:0] v, input int pulse_at,
                         input logic [19:0] v2, output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    load    = 1'b1;
    mileage = v;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      load = (i == pulse_at);
      if (i == pulse_at) mileage = v2;
      if (busy) busy_cycles++;
      else break;
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; mileage = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (tube_sel !== 8'h00 || seg !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tube_sel=%h seg=%h busy=%b, required 00 00 0", tube_sel, seg, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b, required 0", busy);
    end
    capture_scan();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] et, es;
      et = (k < 4) ? 8'h01 : 8'h00;
      es = (k < 4) ? 8'h3F : 8'h00;
      checks++;
      if (cap_t[k] !== et || cap_s[k] !== es) begin
        errors++;
        $display("FAIL reset_display[%0d]: tube_sel=%h seg=%h, required %h %h", k, cap_t[k], cap_s[k], et, es);
      end
    end
  endtask

  task automatic test_main();
    int n;
    logic [7:0] e_t [6];
    logic [7:0] e_s [6];
    logic [7:0] hi;
    e_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    e_s = '{8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
    do_load(20'd123456, 0, '0, n);
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL main_busy_len: busy cycles=%0d, required 20", n);
    end
    capture_scan();
    hi = '0;
    for (int k = 0; k < 24; k++) begin
      hi |= cap_t[k];
      checks++;
      if (cap_t[k] !== e_t[k/4] || cap_s[k] !== e_s[k/4]) begin
        errors++;
        $display("FAIL main_scan[%0d]: tube_sel=%h seg=%h, required %h %h", k, cap_t[k], cap_s[k], e_t[k/4], e_s[k/4]);
      end
    end
    checks++;
    if (hi[7:6] !== 2'b00) begin
      errors++;
      $display("FAIL main_tube67: tube bits 7:6=%b, required 00", hi[7:6]);
    end
  endtask

  task automatic test_blanking();
    int n;
    logic [7:0] e_t [6];
    logic [7:0] e_s [6];
    e_t = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    e_s = '{8'h5B, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(20'd42, 0, '0, n);
    capture_scan();
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (cap_t[k] !== e_t[k/4] || cap_s[k] !== e_s[k/4]) begin
        errors++;
        $display("FAIL blank42[%0d]: tube_sel=%h seg=%h, required %h %h", k, cap_t[k], cap_s[k], e_t[k/4], e_s[k/4]);
      end
    end
    e_t = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    e_s = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(20'd0, 0, '0, n);
    capture_scan();
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (cap_t[k] !== e_t[k/4] || cap_s[k] !== e_s[k/4]) begin
        errors++;
        $display("FAIL blank0[%0d]: tube_sel=%h seg=%h, required %h %h", k, cap_t[k], cap_s[k], e_t[k/4], e_s[k/4]);
      end
    end
  endtask

  task automatic test_clamp();
    int n;
    logic [7:0] e_t [6];
    logic [19:0] vals [2];
    e_t  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    vals = '{20'd1048575, 20'd999999};
    for (int v = 0; v < 2; v++) begin
      do_load(vals[v], 0, '0, n);
      capture_scan();
      for (int k = 0; k < 24; k++) begin
        checks++;
        if (cap_t[k] !== e_t[k/4] || cap_s[k] !== 8'h6F) begin
          errors++;
          $display("FAIL clamp_%0d[%0d]: tube_sel=%h seg=%h, required %h 6f", vals[v], k, cap_t[k], cap_s[k], e_t[k/4]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [7:0] e_t [6];
    logic [7:0] e_s [6];
    e_t = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00};
    e_s = '{8'h3F, 8'h3F, 8'h06, 8'h00, 8'h00, 8'h00};
    do_load(20'd100, 5, 20'd200, n);
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL ignore_busy_len: busy cycles=%0d, required 20", n);
    end
    capture_scan();
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (cap_t[k] !== e_t[k/4] || cap_s[k] !== e_s[k/4]) begin
        errors++;
        $display("FAIL ignore_keep100[%0d]: tube_sel=%h seg=%h, required %h %h", k, cap_t[k], cap_s[k], e_t[k/4], e_s[k/4]);
      end
    end
    // Load on the completion edge must be dropped.
    do_load(20'd300, 20, 20'd400, n);
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL ignore_on_done: busy cycles=%0d, required 20", n);
    end
    // One cycle after busy falls the load is accepted.
    load    = 1'b1;
    mileage = 20'd7;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_after_busy: busy=%b, required 1", busy);
    end
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    capture_scan();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] et, es;
      et = (k < 4) ? 8'h01 : 8'h00;
      es = (k < 4) ? 8'h07 : 8'h00;
      checks++;
      if (cap_t[k] !== et || cap_s[k] !== es) begin
        errors++;
        $display("FAIL accept_show7[%0d]: tube_sel=%h seg=%h, required %h %h", k, cap_t[k], cap_s[k], et, es);
      end
    end
  endtask

  task automatic test_enable();
    int n;
    bit ok;
    do_load(20'd123456, 0, '0, n);
    repeat (2) @(negedge clk);
    sync_slot0(ok);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (tube_sel !== 8'h00 || seg !== 8'h00) begin
        errors++;
        $display("FAIL enable_off[%0d]: tube_sel=%h seg=%h, required 00 00", k, tube_sel, seg);
      end
    end
    enable = 1'b1;
    for (int k = 13; k <= 16; k++) begin
      logic [7:0] et, es;
      @(negedge clk);
      et = (k < 16) ? 8'h08 : 8'h10;
      es = (k < 16) ? 8'h4F : 8'h5B;
      checks++;
      if (tube_sel !== et || seg !== es) begin
        errors++;
        $display("FAIL enable_resume[%0d]: tube_sel=%h seg=%h, required %h %h", k, tube_sel, seg, et, es);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    load    = 1'b1;
    mileage = 20'd555555;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_before: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tube_sel !== 8'h00 || seg !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: tube_sel=%h seg=%h busy=%b, required 00 00 0", tube_sel, seg, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_busy_after[%0d]: busy=%b, required 0", i, busy);
      end
    end
    capture_scan();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] et, es;
      et = (k < 4) ? 8'h01 : 8'h00;
      es = (k < 4) ? 8'h3F : 8'h00;
      checks++;
      if (cap_t[k] !== et || cap_s[k] !== es) begin
        errors++;
        $display("FAIL rstmid_display[%0d]: tube_sel=%h seg=%h, required %h %h", k, cap_t[k], cap_s[k], et, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_blanking();
    test_clamp();
    test_busy_ignore();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mileage_tube_driver.md
Name: mileage_tube_driver

Overview:
Display end of the mileage path. Accepts a binary mileage value from the car mileage counter on a load strobe, converts it to six BCD digits with a serial shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto the board's 8-tube seven-segment display. Sits between the mileage counter and the top-level tube pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit); legal range 2 or more.
BIN_W, 20, mileage input width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  display power (car on); 0 = all tubes dark
load  in  1  single-cycle strobe; capture mileage
mileage  in  BIN_W  binary mileage
busy  out  1  conversion in progress
tube_sel  out  8  tube enables, active-high; bit 0 = rightmost (units)
seg  out  8  segments, active-high; seg[0..6] = a..g, seg[7] = dp

Behaviour:
- Reset (async, rst_n=0): tube_sel=0, seg=0, busy=0, display BCD register=000000, scan index=0, divider=0, converter idle. Reset mid-conversion aborts it; display returns to 0.
- Converter FSM IDLE -> CONV -> IDLE.
  - IDLE, load=1 at edge T: capture min(mileage, 999999) into the shift register and clear the BCD accumulator. Go to CONV; busy=1 from T+1.
  - CONV: one iteration per clock. Add 3 to every nibble >=5, then shift left 1. Exactly BIN_W (20) iterations.
  - On the 20th iteration edge (T+20): load the result into the display register atomically, set busy=0, go to IDLE.
  - load while busy is ignored. There is no queue.
- Clamp: inputs >999999 (up to 1048575) display 999999.
- Scan: divider counts 0..SCAN_DIV-1. On wrap, the scan index advances 0->1->...->5->0. Tubes 6 and 7 are never enabled.
- Outputs are registered. tube_sel/seg reflect the current index and the display register one cycle after either changes.
- Active slot i: tube_sel = one-hot bit i, seg = pattern(digit i). Blanked slot: tube_sel=0, seg=0.
- Leading-zero blanking: slot i (i>=1) is blanked when digits i..5 are all zero. Slot 0 always shows, so a value of 0 shows "0".
- Patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. dp is always 0.
- enable=0 forces tube_sel=0 and seg=0 on the next edge. Scan and conversion keep running. When enable returns to 1, the display resumes from the current index with no reset.
- Simultaneous load and conversion completion: completion takes priority; that load is ignored because busy is still 1 on that edge.

Decomposition:
- Shared package: SEG_PATTERN constants 0-9, NUM_DIGITS=6, MAX_MILEAGE=999999, BIN_W default.
- One sub-module, bin2bcd_serial, contains the converter FSM and the 20-iteration double-dabble. Its interface is clk, rst_n, start, bin, busy, done, bcd[23:0].
- Scan divider, blanking and segment lookup stay in the top module.

Test Plan:
1. Reset, then SCAN_DIV=4, enable=1, load 123456 -> busy high for exactly 20 cycles. The display then cycles tube_sel 0x01/seg 0x7D, 0x02/0x6D, 0x04/0x66, 0x08/0x4F, 0x10/0x5B, 0x20/0x06, each slot held 4 cycles. tube_sel bits 7:6 are never set.
2. Load 42 -> slot 0 shows 0x01/0x5B and slot 1 shows 0x02/0x66. Slots 2-5 output tube_sel=0, seg=0. Load 0 -> only slot 0 lights, seg 0x3F.
3. Load 1048575 -> display 999999, all six slots seg 0x6F. Load 999999 gives an identical result.
4. Load 100 -> slot 2 shows 1. Pulse load 200 at busy cycle 5 -> ignored; 100 is kept. Then pulse load exactly one cycle after busy falls -> accepted.
5. enable=0 for 10 cycles during a scan -> tube_sel=0 and seg=0 from the next edge. On re-enable, output continues at the advanced index.
6. rst_n low at busy cycle 10 of loading 555555 -> all outputs 0 immediately (async). After release, the display shows slot 0 only as "0" and busy=0.
